// File: rtl/wb_port_arbiter.sv
// Two-source register-file write-port arbiter: in-order pipeline writeback vs. buffered MDU results.
// Optional pending-write scoreboard enabled by defining WBARB_SCOREBOARD_EN.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_wd,
  input  logic [63:0] pipe_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wd,
  input  logic [63:0] mdu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wd,
  output logic        wbEn,
  output logic [4:0]  wd,
  output logic [63:0] wbData,
  output logic        cm_valid,
  output logic        cm_src,
  output logic [31:0] busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifoWd   [FIFO_DEPTH];
  logic [63:0]      fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starveCnt;

  logic        mduHead;
  logic        starved;
  logic        grantPipe;
  logic        grantMdu;
  logic        grant;
  logic        push;
  logic [4:0]  gWd;
  logic [63:0] gData;

  // p0: arbitration on the current requests and FIFO head
  always_comb begin
    mduHead   = (count != '0);
    starved   = (starveCnt == STV_W'(STARVE_LIMIT));
    grantPipe = pipe_valid && !(starved && mduHead);
    grantMdu  = mduHead && !grantPipe;
    grant     = grantPipe || grantMdu;
    mdu_ready = (count < CNT_W'(FIFO_DEPTH));
    push      = mdu_valid && mdu_ready;
    gWd       = grantMdu ? fifoWd[rdPtr]   : pipe_wd;
    gData     = grantMdu ? fifoData[rdPtr] : pipe_data;
  end

  assign pipe_ready = grantPipe;

  // FIFO storage carries data only, so it is not reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifoWd[wrPtr]   <= mdu_wd;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PTR_W'(1);
      if (grantMdu)
        rdPtr <= rdPtr + PTR_W'(1);
      if (push && !grantMdu)
        count <= count + CNT_W'(1);
      else if (!push && grantMdu)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !mduHead || grantMdu)
      starveCnt <= '0;
    else if (grantPipe && !starved)
      starveCnt <= starveCnt + STV_W'(1);
  end

  // p1: registered write port and commit report
  always_ff @(posedge clk) begin
    if (rst) begin
      wbEn     <= 1'b0;
      wd       <= '0;
      wbData   <= '0;
      cm_valid <= 1'b0;
      cm_src   <= 1'b0;
    end else begin
      wbEn     <= grant && (gWd != 5'd0);
      cm_valid <= grant;
      if (grant) begin
        wd     <= gWd;
        wbData <= gData;
        cm_src <= grantMdu;
      end
    end
  end

`ifdef WBARB_SCOREBOARD_EN
  logic [31:0] busyQ;
  logic [31:0] busyNext;

  // Set is applied after clear so a same-cycle reissue keeps the bit
  always_comb begin
    busyNext = busyQ;
    if (grantMdu)
      busyNext[gWd] = 1'b0;
    if (iss_valid)
      busyNext[iss_wd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busyQ <= '0;
    else
      busyQ <= busyNext;
  end

  assign busy = busyQ;
`else
  logic unusedIss;
  assign unusedIss = ^{iss_valid, iss_wd};
  assign busy      = 32'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [4:0]  pipe_wd;
  logic [63:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wd;
  logic [63:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_wd;
  logic        wbEn;
  logic [4:0]  wd;
  logic [63:0] wbData;
  logic        cm_valid;
  logic        cm_src;
  logic [31:0] busy;

  int nChecks = 0;
  int nFails  = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wd(pipe_wd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wd(mdu_wd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_wd(iss_wd),
    .wbEn(wbEn), .wd(wd), .wbData(wbData),
    .cm_valid(cm_valid), .cm_src(cm_src), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_wd = '0; pipe_data = '0;
    mdu_valid = 1'b0;  mdu_wd = '0;  mdu_data = '0;
    iss_valid = 1'b0;  iss_wd = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checkVal("rst_wbEn", 64'(wbEn), 64'd0);
    checkVal("rst_wd", 64'(wd), 64'd0);
    checkVal("rst_wbData", wbData, 64'd0);
    checkVal("rst_cm_valid", 64'(cm_valid), 64'd0);
    checkVal("rst_cm_src", 64'(cm_src), 64'd0);
    checkVal("rst_mdu_ready", 64'(mdu_ready), 64'd1);
    checkVal("rst_busy", 64'(busy), 64'd0);

    // Pipe only
    pipe_valid = 1'b1; pipe_wd = 5'd5; pipe_data = 64'h1234;
    settle();
    checkVal("pipe_ready", 64'(pipe_ready), 64'd1);
    tick();
    pipe_valid = 1'b0;
    checkVal("pipe_wbEn", 64'(wbEn), 64'd1);
    checkVal("pipe_wd", 64'(wd), 64'd5);
    checkVal("pipe_wbData", wbData, 64'h1234);
    checkVal("pipe_cm_valid", 64'(cm_valid), 64'd1);
    checkVal("pipe_cm_src", 64'(cm_src), 64'd0);
    tick();
    checkVal("idle_wbEn", 64'(wbEn), 64'd0);
    checkVal("idle_cm_valid", 64'(cm_valid), 64'd0);
    checkVal("idle_wd_hold", 64'(wd), 64'd5);
    checkVal("idle_data_hold", wbData, 64'h1234);

    // MDU only: two-cycle latency from push to visible write
    mdu_valid = 1'b1; mdu_wd = 5'd7; mdu_data = 64'hAA;
    settle();
    checkVal("mdu_ready_empty", 64'(mdu_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    checkVal("mdu_no_bypass", 64'(cm_valid), 64'd0);
    tick();
    checkVal("mdu_wbEn", 64'(wbEn), 64'd1);
    checkVal("mdu_wd", 64'(wd), 64'd7);
    checkVal("mdu_wbData", wbData, 64'hAA);
    checkVal("mdu_cm_src", 64'(cm_src), 64'd1);
    tick();
    checkVal("mdu_drained", 64'(cm_valid), 64'd0);

    // Starvation: pipe held while the FIFO holds wd=9
    pipe_valid = 1'b1; pipe_wd = 5'd10; pipe_data = 64'h10;
    mdu_valid = 1'b1;  mdu_wd = 5'd9;   mdu_data = 64'h99;
    settle();
    checkVal("stv_first_pipe", 64'(pipe_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      checkVal($sformatf("stv_pipe_win%0d", i), 64'(pipe_ready), 64'd1);
      tick();
      checkVal($sformatf("stv_src_pipe%0d", i), 64'(cm_src), 64'd0);
    end
    settle();
    checkVal("stv_pipe_blocked", 64'(pipe_ready), 64'd0);
    tick();
    checkVal("stv_mdu_src", 64'(cm_src), 64'd1);
    checkVal("stv_mdu_wd", 64'(wd), 64'd9);
    checkVal("stv_mdu_data", wbData, 64'h99);
    settle();
    checkVal("stv_pipe_resume", 64'(pipe_ready), 64'd1);
    tick();
    pipe_valid = 1'b0;
    checkVal("stv_resume_wd", 64'(wd), 64'd10);
    checkVal("stv_resume_src", 64'(cm_src), 64'd0);
    tick();

    // Full FIFO under pipe traffic
    pipe_valid = 1'b1; pipe_wd = 5'd11; pipe_data = 64'h111;
    mdu_valid = 1'b1;  mdu_wd = 5'd12;  mdu_data = 64'hC1;
    settle();
    checkVal("full_ready0", 64'(mdu_ready), 64'd1);
    tick();
    mdu_wd = 5'd13; mdu_data = 64'hC2;
    settle();
    checkVal("full_ready1", 64'(mdu_ready), 64'd1);
    tick();
    mdu_wd = 5'd14; mdu_data = 64'hC3;
    settle();
    checkVal("full_blocked", 64'(mdu_ready), 64'd0);
    tick();
    checkVal("full_pipe_wd", 64'(wd), 64'd11);
    pipe_valid = 1'b0;
    settle();
    checkVal("full_no_passthru", 64'(mdu_ready), 64'd0);
    tick();
    checkVal("full_pop1_wd", 64'(wd), 64'd12);
    checkVal("full_pop1_data", wbData, 64'hC1);
    checkVal("full_pop1_src", 64'(cm_src), 64'd1);
    settle();
    checkVal("full_ready_after_pop", 64'(mdu_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    checkVal("full_pop2_wd", 64'(wd), 64'd13);
    checkVal("full_pop2_data", wbData, 64'hC2);
    tick();
    checkVal("full_pop3_wd", 64'(wd), 64'd14);
    checkVal("full_pop3_data", wbData, 64'hC3);
    tick();
    checkVal("full_drained", 64'(cm_valid), 64'd0);

    // Destination x0
    pipe_valid = 1'b1; pipe_wd = 5'd0; pipe_data = 64'h55;
    settle();
    checkVal("x0_ready", 64'(pipe_ready), 64'd1);
    tick();
    pipe_valid = 1'b0;
    checkVal("x0_cm_valid", 64'(cm_valid), 64'd1);
    checkVal("x0_wbEn", 64'(wbEn), 64'd0);
    checkVal("x0_wd", 64'(wd), 64'd0);
    tick();

    // Scoreboard
    iss_valid = 1'b1; iss_wd = 5'd3;
    tick();
    iss_valid = 1'b0;
`ifdef WBARB_SCOREBOARD_EN
    checkVal("sb_set", 64'(busy), 64'h8);
`else
    checkVal("sb_off_set", 64'(busy), 64'h0);
`endif
    mdu_valid = 1'b1; mdu_wd = 5'd3; mdu_data = 64'h33;
    tick();
    mdu_valid = 1'b0;
    tick();
    checkVal("sb_wr_wd", 64'(wd), 64'd3);
    checkVal("sb_clear", 64'(busy), 64'h0);
    iss_valid = 1'b1; iss_wd = 5'd3;
    tick();
    iss_valid = 1'b0;
    mdu_valid = 1'b1;
    tick();
    mdu_valid = 1'b0;
    iss_valid = 1'b1; iss_wd = 5'd3;
    tick();
    iss_valid = 1'b0;
    checkVal("sb_race_wd", 64'(wd), 64'd3);
`ifdef WBARB_SCOREBOARD_EN
    checkVal("sb_set_wins", 64'(busy), 64'h8);
`else
    checkVal("sb_off_race", 64'(busy), 64'h0);
`endif
    iss_valid = 1'b1; iss_wd = 5'd0;
    tick();
    iss_valid = 1'b0;
`ifdef WBARB_SCOREBOARD_EN
    checkVal("sb_x0", 64'(busy), 64'h8);
`else
    checkVal("sb_off_x0", 64'(busy), 64'h0);
`endif

    // Reset with two FIFO entries pending
    pipe_valid = 1'b1; pipe_wd = 5'd20; pipe_data = 64'h200;
    mdu_valid = 1'b1;  mdu_wd = 5'd21;  mdu_data = 64'h210;
    tick();
    mdu_wd = 5'd22; mdu_data = 64'h220;
    tick();
    settle();
    checkVal("pre_rst_full", 64'(mdu_ready), 64'd0);
    rst = 1'b1; pipe_valid = 1'b0; mdu_valid = 1'b0;
    tick();
    rst = 1'b0;
    checkVal("mrst_mdu_ready", 64'(mdu_ready), 64'd1);
    checkVal("mrst_wbEn", 64'(wbEn), 64'd0);
    checkVal("mrst_cm_valid", 64'(cm_valid), 64'd0);
    checkVal("mrst_busy", 64'(busy), 64'h0);
    tick();
    checkVal("mrst_discarded", 64'(cm_valid), 64'd0);
    checkVal("mrst_no_write", 64'(wbEn), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
